// File: rtl/alu_seq_flags.sv
// Handshaked sequential ALU: base ops, ADC/SBC/CMP and an iterative unsigned MUL, with NZCV flags.
// Latency: 1 cycle for non-MUL ops, NBits+1 cycles for MUL; result and flags are registered.
// Backpressure: result is held in DONE while out_ready=0; in_ready stays low until it is consumed.
module alu_seq_flags #(
  parameter int NBits = 8,
  localparam int SHW = $clog2(NBits)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       selection,
  input  logic [NBits-1:0] A,
  input  logic [NBits-1:0] B,
  input  logic             carry_in,
  input  logic             update_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBits-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       flags_q
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam int M = NBits - 1;
  localparam logic [NBits-1:0] NB_VAL = NBits'(NBits);
  localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(NBits);

  state_t state, state_nx;
  logic accept, is_mul;
  logic upd_q;
  logic [2*NBits-1:0] acc, mcand;
  logic [NBits-1:0] mplier;
  logic [SHW:0] cnt;

  // single-cycle datapath, evaluated on the live request inputs
  logic add_cin, sub_cin, shift_big, add_v, sub_v;
  logic [NBits:0] add_full, sub_full;
  logic [SHW-1:0] sh;
  logic [NBits-1:0] sra_val, alu_res;
  logic alu_n, alu_z, alu_c, alu_v, alu_rsvd;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (selection == 4'd11);
  assign out_valid = (state == DONE);

  // ADC/SBC take carry from the committed flag register; SUB/CMP subtract with no borrow-in
  assign add_cin  = (selection == 4'd9) ? flags_q[1] : carry_in;
  assign sub_cin  = (selection == 4'd10) ? flags_q[1] : 1'b1;
  assign add_full = {1'b0, A} + {1'b0, B} + (NBits + 1)'(add_cin);
  assign sub_full = {1'b0, A} + {1'b0, ~B} + (NBits + 1)'(sub_cin);
  assign add_v    = (A[M] == B[M]) & (add_full[M] != A[M]);
  assign sub_v    = (A[M] != B[M]) & (sub_full[M] != A[M]);
  assign shift_big = (B >= NB_VAL);
  assign sh        = B[SHW-1:0];
  assign sra_val   = $signed(A) >>> sh;

  // opcode decode and flag generation for every op that completes in one cycle
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_rsvd = 1'b0;
    unique case (selection)
      4'd0, 4'd9:  begin alu_res = add_full[M:0]; alu_c = add_full[NBits]; alu_v = add_v; end
      4'd1, 4'd10: begin alu_res = sub_full[M:0]; alu_c = sub_full[NBits]; alu_v = sub_v; end
      4'd2:  alu_res = A & B;
      4'd3:  alu_res = A | B;
      4'd4:  alu_res = ~A;
      4'd5:  alu_res = A ^ B;
      4'd6:  alu_res = shift_big ? '0 : (A << sh);
      4'd7:  alu_res = shift_big ? '0 : (A >> sh);
      4'd8:  alu_res = shift_big ? {NBits{A[M]}} : sra_val;
      4'd12: begin alu_c = sub_full[NBits]; alu_v = sub_v; end
      default: alu_rsvd = 1'b1;
    endcase
    alu_n = alu_res[M];
    alu_z = (alu_res == '0);
    // CMP discards the difference but reports its zero-ness
    if (selection == 4'd12) alu_z = (sub_full[M:0] == '0);
    // reserved opcodes report no flags at all
    if (alu_rsvd) alu_z = 1'b0;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: a new accept always wins; otherwise EXEC finishes or DONE drains
  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = is_mul ? EXEC : DONE;
    end else begin
      unique case (state)
        EXEC:    if (cnt == CNT_LAST) state_nx = DONE;
        DONE:    if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // result/flag registers, flag register commit and shift-add multiplier
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      flags_q   <= '0;
      upd_q     <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else if (accept) begin
      upd_q <= update_flags;
      if (is_mul) begin
        acc    <= '0;
        mcand  <= {{NBits{1'b0}}, A};
        mplier <= B;
        cnt    <= '0;
      end else begin
        result    <= alu_res;
        negative  <= alu_n;
        zero      <= alu_z;
        carry_out <= alu_c;
        overflow  <= alu_v;
        if (update_flags && !alu_rsvd) flags_q <= {alu_n, alu_z, alu_c, alu_v};
      end
    end else if (state == EXEC) begin
      if (cnt == CNT_LAST) begin
        // one extra cycle after the last partial product to publish the result
        result    <= acc[M:0];
        negative  <= acc[M];
        zero      <= (acc[M:0] == '0);
        carry_out <= |acc[2*NBits-1:NBits];
        overflow  <= 1'b0;
        if (upd_q) flags_q <= {acc[M], (acc[M:0] == '0), |acc[2*NBits-1:NBits], 1'b0};
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_flags.sv
// Scoreboard bench for alu_seq_flags: expectations are queued at accept and checked when output is presented.
// Directed cases cover reset, latency, chaining, MUL timing, backpressure and shift/CMP edges; then a random run.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_alu_seq_flags;

  typedef struct {
    logic [7:0] res;
    logic [3:0] nzcv;
    logic [3:0] fq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, carry_in, update_flags, out_valid, out_ready;
  logic [3:0] selection, flags_q;
  logic [7:0] A, B, result;
  logic       zero, negative, carry_out, overflow;

  exp_t sb_q[$];
  exp_t cur;
  logic [3:0] fq_m;
  logic rnd_bp;
  int n_chk = 0;
  int n_fail = 0;
  int waits;

  alu_seq_flags #(.NBits(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .selection(selection), .A(A), .B(B), .carry_in(carry_in),
    .update_flags(update_flags), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry_out(carry_out),
    .overflow(overflow), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference behaviour written with plain integer arithmetic
  function automatic exp_t model(input int op, input int a, input int b, input int cin,
                                 input logic [3:0] fq, input logic upd);
    exp_t e;
    int r, s, sa, sb, bw, sh, p;
    logic n, z, c, v;
    r = 0; c = 1'b0; v = 1'b0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0, 9: begin
        bw = (op == 9) ? int'(fq[1]) : cin;
        s = a + b + bw; r = s & 255; c = (s > 255);
        v = ((sa + sb + bw) > 127) || ((sa + sb + bw) < -128);
      end
      1, 10, 12: begin
        bw = (op == 10) ? int'(!fq[1]) : 0;
        s = a - b - bw; r = s & 255; c = (s >= 0);
        v = ((sa - sb - bw) > 127) || ((sa - sb - bw) < -128);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = (~a) & 255;
      5: r = a ^ b;
      6: r = (b >= 8) ? 0 : ((a << b) & 255);
      7: r = (b >= 8) ? 0 : (a >> b);
      8: begin sh = (b >= 8) ? 7 : b; r = (sa >>> sh) & 255; end
      11: begin p = a * b; r = p & 255; c = (p > 255); end
      default: r = 0;
    endcase
    z = (r == 0);
    n = (r > 127);
    if (op == 12) begin r = 0; n = 1'b0; end
    if (op > 12) begin z = 1'b0; n = 1'b0; end
    e.res  = 8'(r);
    e.nzcv = {n, z, c, v};
    e.fq   = (upd && op <= 12) ? {n, z, c, v} : fq;
    return e;
  endfunction

  // drive one request and hold it until accepted; waits = number of edges taken
  task automatic send(input int op, input int a, input int b, input logic cin, input logic upd,
                      output int nw);
    exp_t e;
    bit acc;
    selection = 4'(op); A = 8'(a); B = 8'(b); carry_in = cin; update_flags = upd;
    in_valid = 1'b1;
    acc = 1'b0;
    nw = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(op, a, b, int'(cin), fq_m, upd);
        fq_m = e.fq;
        sb_q.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      nw++;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  // output monitor: compare the head of the scoreboard whenever a result is presented
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        cur = sb_q[0];
        chk("result", 32'(result), 32'(cur.res));
        chk("nzcv", 32'({negative, zero, carry_out, overflow}), 32'(cur.nzcv));
        chk("flags_q", 32'(flags_q), 32'(cur.fq));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rnd_bp = 1'b0;
    selection = '0; A = '0; B = '0; carry_in = 1'b0; update_flags = 1'b0;
    fq_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags_q", 32'(flags_q), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD with signed overflow, result one cycle after accept
    send(0, 8'h7F, 8'h01, 1'b0, 1'b0, waits);
    @(negedge clk);
    chk("add_latency", 32'(out_valid), 32'd1);
    chk("add_nzcv", 32'({negative, zero, carry_out, overflow}), 32'b1001);
    @(posedge clk); #1;

    // carry chain: ADD sets C, back-to-back ADC consumes it
    send(0, 8'hFF, 8'h01, 1'b0, 1'b1, waits);
    send(9, 8'h00, 8'h00, 1'b0, 1'b0, waits);
    chk("adc_b2b_wait", 32'(waits), 32'd1);
    @(negedge clk);
    chk("adc_result", 32'(result), 32'h01);
    @(posedge clk); #1;

    // MUL timing: busy for NBits+1 cycles, in_ready low throughout
    send(11, 20, 15, 1'b0, 1'b1, waits);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("mul_busy_valid", 32'(out_valid), 32'd0);
      chk("mul_busy_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_result", 32'(result), 32'h2C);
    chk("mul_carry", 32'(carry_out), 32'd1);
    @(posedge clk); #1;

    // backpressure: result must hold for 5 cycles, next op taken on release
    out_ready = 1'b0;
    send(1, 8'h05, 8'h07, 1'b0, 1'b1, waits);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(result), 32'hFE);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(10, 8'h10, 8'h01, 1'b0, 1'b1, waits);
    chk("bp_release_wait", 32'(waits), 32'd1);

    // shift and compare edges
    send(8, 8'h90, 8'd9, 1'b0, 1'b0, waits);
    send(6, 8'hA5, 8'd8, 1'b0, 1'b0, waits);
    send(7, 8'hA5, 8'd3, 1'b0, 1'b0, waits);
    send(12, 8'h33, 8'h33, 1'b0, 1'b1, waits);
    @(negedge clk);
    chk("cmp_result", 32'(result), 32'd0);
    chk("cmp_zc", 32'({zero, carry_out}), 32'b11);
    @(posedge clk); #1;
    send(14, 8'h00, 8'h00, 1'b0, 1'b1, waits);
    send(4, 8'h0F, 8'h00, 1'b0, 1'b1, waits);
    repeat (2) @(posedge clk); #1;

    // reset mid-MUL discards the operation and clears all state
    send(11, 8'hFF, 8'hFF, 1'b0, 1'b1, waits);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    sb_q.delete();
    fq_m = '0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_flags_q", 32'(flags_q), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random ops with random output backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send($urandom_range(0, 15), $urandom_range(0, 255),
           ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 9),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), waits);
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
